// File: rtl/hpt_axis_pkg.sv
// -----------------------------------------------------------------------------
// hpt_axis_pkg
// Shared definitions for the HPT-axis blocks (normal raise cycle and the
// hyperthyroid suppression cycle): state encodings, body-state/response codes
// and the 10-bit one-hot image selects consumed by the display/mux logic.
// No ports (package).
// -----------------------------------------------------------------------------
package hpt_axis_pkg;

    // Suppression-cycle states. Codes 6 and 7 are unused and recover to NORMAL.
    typedef enum logic [2:0] {
        ST_NORMAL       = 3'd0,
        ST_TRIGGERED    = 3'd1,
        ST_INHIBIT_HYPO = 3'd2,
        ST_INHIBIT_PIT  = 3'd3,
        ST_INHIBIT_THY  = 3'd4,
        ST_REESTABLISH  = 3'd5
    } state_e;

    // Body-state / response codes, shared by both cycle directions.
    typedef enum logic [1:0] {
        RESP_HEALTHY = 2'b00,
        RESP_LOW     = 2'b01,
        RESP_HIGH    = 2'b10
    } resp_e;

    // Image selects. Slots 1..4 belong to the normal (raise) cycle.
    localparam logic [9:0] IMG_NORMAL       = 10'b00_0000_0001;
    localparam logic [9:0] IMG_RAISE_1      = 10'b00_0000_0010;
    localparam logic [9:0] IMG_RAISE_2      = 10'b00_0000_0100;
    localparam logic [9:0] IMG_RAISE_3      = 10'b00_0000_1000;
    localparam logic [9:0] IMG_RAISE_4      = 10'b00_0001_0000;
    localparam logic [9:0] IMG_REESTABLISH  = 10'b00_0010_0000;
    localparam logic [9:0] IMG_TRIGGERED    = 10'b00_0100_0000;
    localparam logic [9:0] IMG_INHIBIT_HYPO = 10'b00_1000_0000;
    localparam logic [9:0] IMG_INHIBIT_PIT  = 10'b01_0000_0000;
    localparam logic [9:0] IMG_INHIBIT_THY  = 10'b10_0000_0000;

    function automatic logic [9:0] image_of(state_e s);
        case (s)
            ST_TRIGGERED:    return IMG_TRIGGERED;
            ST_INHIBIT_HYPO: return IMG_INHIBIT_HYPO;
            ST_INHIBIT_PIT:  return IMG_INHIBIT_PIT;
            ST_INHIBIT_THY:  return IMG_INHIBIT_THY;
            ST_REESTABLISH:  return IMG_REESTABLISH;
            default:         return IMG_NORMAL;
        endcase
    endfunction

    // Response reads healthy only at rest and while re-establishing.
    function automatic resp_e response_of(state_e s);
        if (s == ST_NORMAL || s == ST_REESTABLISH) begin
            return RESP_HEALTHY;
        end
        return RESP_HIGH;
    endfunction

endpackage

// File: rtl/hpt_level_decay.sv
// -----------------------------------------------------------------------------
// hpt_level_decay
// T3/T4 level register with a tick divider. The level is loaded high when a
// suppression cycle starts, held at baseline at rest, and decays by DECAY_STEP
// every TICK_DIV cycles while decay_en is high, saturating at NORMAL_LEVEL.
// Ports:
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   load          in   load HIGH_LEVEL (highest priority)
//   hold_baseline in   force NORMAL_LEVEL
//   decay_en      in   run the tick divider and decay on wrap
//   level         out  current level, LEVEL_W bits
// -----------------------------------------------------------------------------
module hpt_level_decay
    import hpt_axis_pkg::*;
#(
    parameter int LEVEL_W      = 8,
    parameter int NORMAL_LEVEL = 128,
    parameter int HIGH_LEVEL   = 192,
    parameter int DECAY_STEP   = 16,
    parameter int TICK_DIV     = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               hold_baseline,
    input  logic               decay_en,
    output logic [LEVEL_W-1:0] level
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0] NORMAL_L  = LEVEL_W'(NORMAL_LEVEL);
    localparam logic [LEVEL_W-1:0] HIGH_L    = LEVEL_W'(HIGH_LEVEL);
    localparam logic [LEVEL_W-1:0] STEP_L    = LEVEL_W'(DECAY_STEP);

    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [LEVEL_W-1:0] level_q, level_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        tick_d  = '0;
        level_d = level_q;
        if (load) begin
            level_d = HIGH_L;
        end else if (hold_baseline) begin
            level_d = NORMAL_L;
        end else if (decay_en) begin
            if (tick_q == TICK_LAST) begin
                // Only subtract when the result stays strictly above the floor;
                // otherwise clamp, so the unsigned subtraction never wraps.
                if (level_q > NORMAL_L && (level_q - NORMAL_L) > STEP_L) begin
                    level_d = level_q - STEP_L;
                end else begin
                    level_d = NORMAL_L;
                end
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (!resetn) begin
            tick_q  <= '0;
            level_q <= NORMAL_L;
        end else begin
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/hpt_axis_suppress.sv
// -----------------------------------------------------------------------------
// hpt_axis_suppress
// Hyperthyroid (high body-state) HPT-axis cycle: a trigger in NORMAL loads a
// high T3/T4 level, then TRH, TSH and finally the thyroid level are suppressed
// in turn until the level decays back to baseline. Flags, response and image
// are registered from the current state and so lag it by one cycle.
// Optional build macro: HPT_SUPPRESS_TIMEOUT_EN adds a dwell watchdog on the
// INHIBIT_* states that forces REESTABLISH and sets a sticky fault.
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   trigger    in   starts a cycle when sampled in NORMAL
//   data_high  out  {state[2:0], response[1:0], TRH_sup, TSH_sup, T4_high}
//   image_high out  one-hot image select (10 bits)
//   level      out  current T3/T4 level (LEVEL_W bits)
//   fault      out  sticky watchdog flag (0 when the watchdog is compiled out)
// -----------------------------------------------------------------------------
module hpt_axis_suppress
    import hpt_axis_pkg::*;
#(
    parameter int LEVEL_W      = 8,
    parameter int NORMAL_LEVEL = 128,
    parameter int HIGH_LEVEL   = 192,
    parameter int DECAY_STEP   = 16,
    parameter int TICK_DIV     = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               trigger,
    output logic [7:0]         data_high,
    output logic [9:0]         image_high,
    output logic [LEVEL_W-1:0] level,
    output logic               fault
);

    localparam logic [LEVEL_W-1:0] NORMAL_L = LEVEL_W'(NORMAL_LEVEL);

    state_e     state_q, state_d;
    resp_e      body_q, body_d;
    resp_e      resp_q, resp_d;
    logic [9:0] image_q, image_d;
    logic       trh_q, trh_d;
    logic       tsh_q, tsh_d;
    logic       t4_q, t4_d;
    logic       timeout_hit;

    // ---------------------------------------------------------------- FSM ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL:       if (trigger)               state_d = ST_TRIGGERED;
            ST_TRIGGERED:    if (body_q == RESP_HIGH)   state_d = ST_INHIBIT_HYPO;
            ST_INHIBIT_HYPO: if (trh_q)                 state_d = ST_INHIBIT_PIT;
            ST_INHIBIT_PIT:  if (tsh_q)                 state_d = ST_INHIBIT_THY;
            ST_INHIBIT_THY:  if (level == NORMAL_L)     state_d = ST_REESTABLISH;
            ST_REESTABLISH:  if (!trh_q && !tsh_q)      state_d = ST_NORMAL;
            default:                                    state_d = ST_NORMAL;
        endcase
        if (timeout_hit) begin
            state_d = ST_REESTABLISH;
        end
    end

    // Datapath flags follow the current state, one cycle behind it.
    always_comb begin
        body_d  = RESP_HEALTHY;
        trh_d   = 1'b0;
        tsh_d   = 1'b0;
        t4_d    = 1'b0;
        resp_d  = response_of(state_q);
        image_d = image_of(state_q);
        case (state_q)
            ST_TRIGGERED: begin
                body_d = RESP_HIGH;
                t4_d   = 1'b1;
            end
            ST_INHIBIT_HYPO: begin
                body_d = RESP_HIGH;
                trh_d  = 1'b1;
                t4_d   = 1'b1;
            end
            ST_INHIBIT_PIT: begin
                body_d = RESP_HIGH;
                trh_d  = 1'b1;
                tsh_d  = 1'b1;
                t4_d   = 1'b1;
            end
            ST_INHIBIT_THY: begin
                body_d = RESP_HIGH;
                trh_d  = 1'b1;
                tsh_d  = 1'b1;
                t4_d   = (level > NORMAL_L);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_NORMAL;
            body_q  <= RESP_HEALTHY;
            resp_q  <= RESP_HEALTHY;
            image_q <= IMG_NORMAL;
            trh_q   <= 1'b0;
            tsh_q   <= 1'b0;
            t4_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            body_q  <= body_d;
            resp_q  <= resp_d;
            image_q <= image_d;
            trh_q   <= trh_d;
            tsh_q   <= tsh_d;
            t4_q    <= t4_d;
        end
    end

    // ------------------------------------------------------ level register ----
    hpt_level_decay #(
        .LEVEL_W      (LEVEL_W),
        .NORMAL_LEVEL (NORMAL_LEVEL),
        .HIGH_LEVEL   (HIGH_LEVEL),
        .DECAY_STEP   (DECAY_STEP),
        .TICK_DIV     (TICK_DIV)
    ) u_level_decay (
        .clk           (clk),
        .resetn        (resetn),
        .load          ((state_q == ST_NORMAL) && trigger),
        .hold_baseline (state_q == ST_NORMAL),
        .decay_en      (state_q == ST_INHIBIT_THY),
        .level         (level)
    );

    // ------------------------------------------------------------ watchdog ----
`ifdef HPT_SUPPRESS_TIMEOUT_EN
    localparam int DWELL_W = $clog2(TIMEOUT + 1);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               fault_q, fault_d;
    logic               in_inhibit;

    // dwell_q counts edges already spent in the current INHIBIT_* state; it
    // never exceeds TIMEOUT because reaching it forces a state change.
    always_comb begin
        in_inhibit  = state_q inside {ST_INHIBIT_HYPO, ST_INHIBIT_PIT, ST_INHIBIT_THY};
        timeout_hit = in_inhibit && (dwell_q >= DWELL_W'(TIMEOUT));
        fault_d     = fault_q | timeout_hit;
    end

    always_comb begin
        dwell_d = '0;
        if (in_inhibit && state_d == state_q) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dwell_q <= '0;
            fault_q <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    // Watchdog compiled out: TIMEOUT is only referenced to keep it visible.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign fault          = 1'b0;
`endif

    assign data_high  = {state_q, resp_q, trh_q, tsh_q, t4_q};
    assign image_high = image_q;

endmodule

// File: tb/tb_hpt_axis_suppress.sv
// -----------------------------------------------------------------------------
// tb_hpt_axis_suppress
// Three instances run side by side: u_a (defaults), u_b (DECAY_STEP=50) and
// u_c (TICK_DIV=32, TIMEOUT=64). A timeline model derives every expected
// output from the edge count since the trigger was accepted; one compare
// process checks all instances on every falling edge, and directed literal
// checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hpt_axis_suppress;

    localparam int N    = 3;
    localparam int HIGH = 192;
    localparam int NORM = 128;
    localparam int TMO  = 64;
`ifdef HPT_SUPPRESS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] trig = '0;

    logic [7:0] dh   [N];
    logic [9:0] img  [N];
    logic [7:0] lvl  [N];
    logic       flt  [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hpt_axis_suppress u_a (
        .clk(clk), .resetn(rstn), .trigger(trig[0]),
        .data_high(dh[0]), .image_high(img[0]), .level(lvl[0]), .fault(flt[0])
    );

    hpt_axis_suppress #(.DECAY_STEP(50)) u_b (
        .clk(clk), .resetn(rstn), .trigger(trig[1]),
        .data_high(dh[1]), .image_high(img[1]), .level(lvl[1]), .fault(flt[1])
    );

    hpt_axis_suppress #(.TICK_DIV(32), .TIMEOUT(TMO)) u_c (
        .clk(clk), .resetn(rstn), .trigger(trig[2]),
        .data_high(dh[2]), .image_high(img[2]), .level(lvl[2]), .fault(flt[2])
    );

    // ------------------------------------------------------------ checking ----
    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic chk_state(string name, int i, int exp);
        logic [7:0] d;
        d = dh[i];
        check(name, 32'(d[7:5]), exp);
    endtask

    // --------------------------------------------------------------- model ----
    function automatic int step_of(int i);
        return (i == 1) ? 50 : 16;
    endfunction

    function automatic int tdiv_of(int i);
        return (i == 2) ? 32 : 4;
    endfunction

    // Timeline relative to the accepting edge (k=0 is TRIGGERED): HYPO at 2,
    // PIT at 4, THY at 6, decrements every TICK_DIV edges after that, exit
    // one edge after the floor is reached (or after TIMEOUT+1 dwell edges).
    function automatic int k_exit(int i);
        int n, ke;
        n  = (HIGH - NORM + step_of(i) - 1) / step_of(i);
        ke = 6 + n * tdiv_of(i) + 1;
        if (TMO_EN && (6 + TMO + 1) < ke) ke = 6 + TMO + 1;
        return ke;
    endfunction

    function automatic bit timed_out(int i);
        int n;
        n = (HIGH - NORM + step_of(i) - 1) / step_of(i);
        return TMO_EN && (6 + TMO + 1) < (6 + n * tdiv_of(i) + 1);
    endfunction

    function automatic int state_at(int i, int k);
        if (k < 2) return 1;
        if (k < 4) return 2;
        if (k < 6) return 3;
        if (k < k_exit(i)) return 4;
        return 5;
    endfunction

    function automatic int level_at(int i, int k);
        int m, nd, v;
        m  = (k < k_exit(i)) ? k : k_exit(i);
        nd = (m >= 6) ? (m - 6) / tdiv_of(i) : 0;
        v  = HIGH - nd * step_of(i);
        return (v < NORM) ? NORM : v;
    endfunction

    function automatic logic [9:0] img_of(int s);
        case (s)
            1:       return 10'h040;
            2:       return 10'h080;
            3:       return 10'h100;
            4:       return 10'h200;
            5:       return 10'h020;
            default: return 10'h001;
        endcase
    endfunction

    bit act   [N];
    int kk    [N];
    int st    [N];
    int pst   [N];
    int lv    [N];
    int plv   [N];
    bit flt_m [N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; kk[i] = 0; st[i] = 0; pst[i] = 0;
            lv[i] = NORM; plv[i] = NORM; flt_m[i] = 1'b0;
        end
    endtask

    function automatic logic [7:0] dh_exp(int i);
        int         s;
        logic [1:0] resp;
        logic       trh, tsh, t4;
        s    = pst[i];
        resp = (s == 0 || s == 5) ? 2'b00 : 2'b10;
        trh  = (s >= 2 && s <= 4);
        tsh  = (s == 3 || s == 4);
        t4   = (s >= 1 && s <= 3) || (s == 4 && plv[i] > NORM);
        return {3'(st[i]), resp, trh, tsh, t4};
    endfunction

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                model_reset();
            end else begin
                for (int i = 0; i < N; i++) begin
                    pst[i] = st[i];
                    plv[i] = lv[i];
                    if (act[i]) begin
                        kk[i]++;
                        if (kk[i] == k_exit(i) + 2) act[i] = 1'b0;
                    end else if (trig[i]) begin
                        act[i] = 1'b1;
                        kk[i]  = 0;
                    end
                    st[i] = act[i] ? state_at(i, kk[i]) : 0;
                    if (pst[i] == 0) lv[i] = act[i] ? HIGH : NORM;
                    else             lv[i] = level_at(i, kk[i]);
                    if (act[i] && kk[i] == k_exit(i) && timed_out(i)) flt_m[i] = 1'b1;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                check($sformatf("u%0d data_high", i), dh[i],  dh_exp(i));
                check($sformatf("u%0d image", i),     img[i], img_of(pst[i]));
                check($sformatf("u%0d level", i),     lvl[i], lv[i]);
                check($sformatf("u%0d fault", i),     flt[i], flt_m[i]);
            end
        end
    end

    // ------------------------------------------------------------ stimulus ----
    task automatic adv(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        rstn = 1'b0;
        trig = '0;
        adv(3);
        check("rst data_high", dh[0], 8'h00);
        check("rst image", img[0], 10'h001);
        check("rst level", lvl[0], 128);
        check("rst fault", flt[0], 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int c = 0; c < 20; c++) begin
            adv(1);
            check("idle data_high", dh[0], 8'h00);
            check("idle image", img[0], 10'h001);
            check("idle level", lvl[0], 128);
        end

        // Single-cycle pulse: trigger sampled at edge 1.
        trig[0] = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            adv(1);
            if (e == 1) trig[0] = 1'b0;
            case (e)
                1:  begin chk_state("p st e1", 0, 1); check("p lvl e1", lvl[0], 192); end
                2:  begin check("p img e2", img[0], 10'h040); check("p dh e2", dh[0], 8'h31); end
                3:  chk_state("p st e3", 0, 2);
                5:  chk_state("p st e5", 0, 3);
                6:  check("p img e6", img[0], 10'h100);
                7:  chk_state("p st e7", 0, 4);
                8:  check("p img e8", img[0], 10'h200);
                10: check("p lvl e10", lvl[0], 192);
                11: check("p lvl e11", lvl[0], 176);
                15: check("p lvl e15", lvl[0], 160);
                19: check("p lvl e19", lvl[0], 144);
                23: check("p lvl e23", lvl[0], 128);
                24: chk_state("p st e24", 0, 5);
                25: check("p img e25", img[0], 10'h020);
                26: chk_state("p st e26", 0, 0);
                27: check("p img e27", img[0], 10'h001);
                default: ;
            endcase
        end

        // Trigger held from INHIBIT_PIT onward: ignored until NORMAL again.
        trig[0] = 1'b1;
        for (int e = 1; e <= 41; e++) begin
            adv(1);
            case (e)
                1:  trig[0] = 1'b0;
                5:  begin chk_state("h st e5", 0, 3); trig[0] = 1'b1; end
                11: check("h lvl e11", lvl[0], 176);
                24: chk_state("h st e24", 0, 5);
                26: chk_state("h st e26", 0, 0);
                27: begin
                        chk_state("h st e27", 0, 1);
                        check("h lvl e27", lvl[0], 192);
                        trig[0] = 1'b0;
                    end
                41: begin chk_state("h st e41", 0, 4); check("h lvl e41", lvl[0], 160); end
                default: ;
            endcase
        end

        // Asynchronous reset in INHIBIT_THY with level 160.
        rstn = 1'b0;
        #1;
        check("mid rst data_high", dh[0], 8'h00);
        check("mid rst level", lvl[0], 128);
        check("mid rst image", img[0], 10'h001);
        @(negedge clk);
        rstn = 1'b1;
        adv(1);

        // DECAY_STEP=50: 192 -> 142 -> 128 (clamped).
        trig[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            adv(1);
            case (e)
                1:  begin trig[1] = 1'b0; check("s50 lvl e1", lvl[1], 192); end
                11: check("s50 lvl e11", lvl[1], 142);
                15: begin check("s50 lvl e15", lvl[1], 128); chk_state("s50 st e15", 1, 4); end
                16: chk_state("s50 st e16", 1, 5);
                18: chk_state("s50 st e18", 1, 0);
                20: check("s50 lvl e20", lvl[1], 128);
                default: ;
            endcase
        end

        // Slow decay (TICK_DIV=32) against the 64-cycle watchdog.
        trig[2] = 1'b1;
        for (int e = 1; e <= 140; e++) begin
            adv(1);
            if (e == 1) trig[2] = 1'b0;
`ifdef HPT_SUPPRESS_TIMEOUT_EN
            case (e)
                39: check("wd lvl e39", lvl[2], 176);
                71: begin chk_state("wd st e71", 2, 4); check("wd fault e71", flt[2], 0); end
                72: begin
                        chk_state("wd st e72", 2, 5);
                        check("wd lvl e72", lvl[2], 160);
                        check("wd fault e72", flt[2], 1);
                    end
                74: begin chk_state("wd st e74", 2, 0); check("wd fault e74", flt[2], 1); end
                80: begin check("wd lvl e80", lvl[2], 128); check("wd fault e80", flt[2], 1); end
                140: check("wd fault e140", flt[2], 1);
                default: ;
            endcase
`else
            case (e)
                39:  check("slow lvl e39", lvl[2], 176);
                72:  begin chk_state("slow st e72", 2, 4); check("slow fault e72", flt[2], 0); end
                136: begin chk_state("slow st e136", 2, 5); check("slow lvl e136", lvl[2], 128); end
                138: chk_state("slow st e138", 2, 0);
                default: ;
            endcase
`endif
        end

        rstn = 1'b0;
        #1;
        check("final rst fault", flt[2], 0);
        check("final rst data_high", dh[2], 8'h00);
        @(negedge clk);
        rstn = 1'b1;
        adv(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpt_axis_suppress.md
Name: hpt_axis_suppress

Overview:
Hyperthyroid (high-bodystate) counterpart of the normal HPT-axis cycle. Where the normal cycle raises hormones for a low bodystate, this block drives the negative-feedback direction. Elevated T3/T4 suppresses hypothalamic TRH, then pituitary TSH, then decays the thyroid level back to baseline. It exports the same 8-bit status byte and 10-bit one-hot image vector format used by the top-level display/mux logic.

Parameters:
LEVEL_W, 8, width of the T3/T4 level register
NORMAL_LEVEL, 128, baseline level; held in NORMAL, decay floor
HIGH_LEVEL, 192, level loaded on trigger
DECAY_STEP, 16, amount subtracted per decay tick
TICK_DIV, 4, clock cycles per decay tick (>=1)
TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
trigger  in  1  level; starts a suppression cycle when sampled in NORMAL
data_high  out  8  {state[2:0], response[1:0], TRH_sup, TSH_sup, T4_high}
image_high  out  10  one-hot image select
level  out  LEVEL_W  current T3/T4 level
fault  out  1  sticky watchdog flag (tied 0 without the optional feature)

Behaviour:
- Single clock clk; reset is asynchronous and active-low on resetn.
- Reset values:
  - state=NORMAL; response=00; image_high=10'b0000000001.
  - TRH_sup=TSH_sup=T4_high=0; bodystate=healthy; level=NORMAL_LEVEL.
  - tick counter=0; fault=0.
- States (3-bit): NORMAL=0, TRIGGERED=1, INHIBIT_HYPO=2, INHIBIT_PIT=3, INHIBIT_THY=4, REESTABLISH=5. Codes 6/7 go to NORMAL next cycle.
- Transitions, evaluated each clk:
  - NORMAL -> TRIGGERED if trigger.
  - TRIGGERED -> INHIBIT_HYPO if bodystate==high.
  - INHIBIT_HYPO -> INHIBIT_PIT if TRH_sup.
  - INHIBIT_PIT -> INHIBIT_THY if TSH_sup.
  - INHIBIT_THY -> REESTABLISH if level==NORMAL_LEVEL.
  - REESTABLISH -> NORMAL if !TRH_sup && !TSH_sup.
  - Otherwise hold. trigger is ignored outside NORMAL.
- Datapath regs are updated from the current state, so they lag state by one cycle:
  - NORMAL: healthy, 0,0,0.
  - TRIGGERED: high, 0,0,1.
  - INHIBIT_HYPO: high, 1,0,1.
  - INHIBIT_PIT: high, 1,1,1.
  - INHIBIT_THY: high, 1,1,(level>NORMAL_LEVEL).
  - REESTABLISH: healthy, 0,0,0.
- Level register:
  - Loaded with HIGH_LEVEL on the edge where NORMAL&&trigger.
  - Forced to NORMAL_LEVEL while in NORMAL.
  - In INHIBIT_THY, the tick counter runs 0..TICK_DIV-1. On wrap, level <= max(level-DECAY_STEP, NORMAL_LEVEL), computed unsigned with no underflow.
  - Tick counter is cleared in every other state.
- Response/image are registered from the current state (one-cycle lag):
  - response = 00 in NORMAL/REESTABLISH, 10 (high) otherwise.
  - image bits: NORMAL bit0, TRIGGERED bit6, INHIBIT_HYPO bit7, INHIBIT_PIT bit8, INHIBIT_THY bit9, REESTABLISH bit5.
- Reset mid-cycle returns everything to reset values immediately. No resumption.
- Default timing from trigger sampled at edge0:
  - TRIGGERED at edge1; INHIBIT_HYPO at edge3; INHIBIT_PIT at edge5; INHIBIT_THY at edge7.
  - Four decrements at edges 11/15/19/23; REESTABLISH at edge24; NORMAL at edge26.

Optional Feature:
- Macro: HPT_SUPPRESS_TIMEOUT_EN.
- Enabled:
  - A dwell counter counts cycles spent in any INHIBIT_* state and resets on each state change.
  - On reaching TIMEOUT, the next state is forced to REESTABLISH and fault is set.
  - fault is sticky until resetn.
- Disabled: no dwell counter; fault is constant 0; no forced exit.

Decomposition:
- Shared package hpt_axis_pkg holds:
  - state encodings;
  - response codes (healthy=00, low=01, high=10);
  - all 10-bit image one-hot constants, shared with the normal-cycle block.
- One sub-module, hpt_level_decay, holds the tick divider and saturating level register. Its inputs are load, hold_baseline and decay_en; its output is level.

Test Plan:
- resetn low then high, trigger=0 for 20 cycles -> state 0, data_high=8'h00, image_high=10'h001, level=128 throughout.
- trigger pulse 1 cycle in NORMAL (defaults) -> state sequence 1,2,3,4,5,0 at edges 1,3,5,7,24,26; level 192,176,160,144,128; image walks bits 6,7,8,9,5,0 one cycle after each state.
- trigger held high during INHIBIT_PIT -> no effect; cycle completes identically. After return to NORMAL with trigger still high, a new cycle starts next edge.
- resetn asserted while in INHIBIT_THY with level=160 -> same cycle: state 0, level 128, all flags 0, response 00.
- DECAY_STEP=50 -> level 192,142,128: saturates at floor, never below 128.
- With HPT_SUPPRESS_TIMEOUT_EN, TICK_DIV=32, TIMEOUT=64 -> forced REESTABLISH before level reaches 128; fault=1 and stays 1 after NORMAL; cleared only by resetn.
